// File: rtl/multicycle_maindec.sv
// ---------------------------------------------------------------------------
// multicycle_maindec
//
// Main control FSM for a multicycle MIPS datapath. Each instruction is
// sequenced over 3-5 states so one memory port and one ALU can be shared.
// Memory accesses stall on mem_ready. Instructions that retire are counted,
// and unsupported opcodes are flagged with a one-cycle illegal_op pulse.
// ALU function decode (funct field) is handled outside this block.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   op         in   [5:0] opcode from the instruction register
//   mem_ready  in   memory finishes the current access this cycle
//   iord       out  memory address select (0 PC, 1 ALUOut)
//   alusrca    out  ALU A select (0 PC, 1 reg A)
//   regdst     out  write register select (0 rt, 1 rd)
//   memtoreg   out  write data select (0 ALUOut, 1 memory data)
//   alusrcb    out  [1:0] 00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   pcsrc      out  [1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   aluop      out  [1:0] 00 add, 01 sub, 10 funct, 11 or
//   irwrite, pcwrite, regwrite, memwrite, branch, branch_ne
//              out  write / branch strobes
//   instr_done out  one-cycle pulse when an instruction retires
//   illegal_op out  one-cycle pulse on an unsupported opcode
//   retired    out  [RETIRE_W-1:0] retired-instruction count (wraps)
//   state      out  [3:0] current state encoding, for debug
// ---------------------------------------------------------------------------
module multicycle_maindec #(
    parameter int SUPPORT_ORI = 1,
    parameter int SUPPORT_BNE = 1,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic                mem_ready,
    output logic                iord,
    output logic                alusrca,
    output logic                regdst,
    output logic                memtoreg,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [1:0]          aluop,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                regwrite,
    output logic                memwrite,
    output logic                branch,
    output logic                branch_ne,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam bit ORI_EN = (SUPPORT_ORI != 0);
    localparam bit BNE_EN = (SUPPORT_BNE != 0);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12,
        S_ORIWB   = 4'd13,
        S_BNEEX   = 4'd14,
        S_UNUSED  = 4'd15
    } state_e;

    state_e                state_q, state_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;

    // -----------------------------------------------------------------------
    // State and retire-counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // instr_done is already masked by reset, so no extra qualification here.
    always_comb begin
        retired_d = retired_q;
        if (instr_done) begin
            retired_d = retired_q + RETIRE_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        alusrca    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    OP_BNE: begin
                        if (BNE_EN) begin
                            state_d = S_BNEEX;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    OP_ORI: begin
                        if (ORI_EN) begin
                            state_d = S_ORIEX;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // op[3] separates SW (101011) from LW (100011).
                state_d = op[3] ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_RTYPEWB;
            end

            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end

            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            // Disabled optional states behave like the unused encoding:
            // silent return to FETCH.
            S_ORIEX: begin
                if (ORI_EN) begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = 2'b11;
                    state_d = S_ORIWB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_ORIWB: begin
                if (ORI_EN) begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                state_d = S_FETCH;
            end

            S_BNEEX: begin
                if (BNE_EN) begin
                    alusrca    = 1'b1;
                    aluop      = 2'b01;
                    pcsrc      = 2'b01;
                    branch_ne  = 1'b1;
                    instr_done = 1'b1;
                end
                state_d = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Strobes are suppressed during reset so an abandoned instruction
        // neither writes state nor retires.
        if (reset) begin
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            branch     = 1'b0;
            branch_ne  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_maindec.sv
// ---------------------------------------------------------------------------
// tb_multicycle_maindec
//
// Scoreboard bench for multicycle_maindec. Two instances share the inputs:
// u_a uses default parameters, u_b disables ORI/BNE and uses a 2-bit retire
// counter. The driver issues one directed cycle at a time with the
// hand-written expected state and pushes the expected outputs; a monitor
// on the falling edge pops and compares against the selected instance.
// ---------------------------------------------------------------------------
module tb_multicycle_maindec;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b1;
    logic [5:0] op = 6'd0;

    always #5 clk = ~clk;

    logic a_iord, a_alusrca, a_regdst, a_memtoreg;
    logic [1:0] a_alusrcb, a_pcsrc, a_aluop;
    logic a_irwrite, a_pcwrite, a_regwrite, a_memwrite, a_branch, a_branch_ne;
    logic a_instr_done, a_illegal_op;
    logic [15:0] a_retired;
    logic [3:0]  a_state;

    logic b_iord, b_alusrca, b_regdst, b_memtoreg;
    logic [1:0] b_alusrcb, b_pcsrc, b_aluop;
    logic b_irwrite, b_pcwrite, b_regwrite, b_memwrite, b_branch, b_branch_ne;
    logic b_instr_done, b_illegal_op;
    logic [1:0]  b_retired;
    logic [3:0]  b_state;

    multicycle_maindec #(.SUPPORT_ORI(1), .SUPPORT_BNE(1), .RETIRE_W(16)) u_a (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .iord(a_iord), .alusrca(a_alusrca), .regdst(a_regdst), .memtoreg(a_memtoreg),
        .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .aluop(a_aluop),
        .irwrite(a_irwrite), .pcwrite(a_pcwrite), .regwrite(a_regwrite),
        .memwrite(a_memwrite), .branch(a_branch), .branch_ne(a_branch_ne),
        .instr_done(a_instr_done), .illegal_op(a_illegal_op),
        .retired(a_retired), .state(a_state)
    );

    multicycle_maindec #(.SUPPORT_ORI(0), .SUPPORT_BNE(0), .RETIRE_W(2)) u_b (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .iord(b_iord), .alusrca(b_alusrca), .regdst(b_regdst), .memtoreg(b_memtoreg),
        .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .aluop(b_aluop),
        .irwrite(b_irwrite), .pcwrite(b_pcwrite), .regwrite(b_regwrite),
        .memwrite(b_memwrite), .branch(b_branch), .branch_ne(b_branch_ne),
        .instr_done(b_instr_done), .illegal_op(b_illegal_op),
        .retired(b_retired), .state(b_state)
    );

    // Output word order:
    // {iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop,
    //  irwrite, pcwrite, regwrite, memwrite, branch, branch_ne, instr_done, illegal_op}
    logic [17:0] a_ctl, b_ctl;
    assign a_ctl = {a_iord, a_alusrca, a_regdst, a_memtoreg, a_alusrcb, a_pcsrc, a_aluop,
                    a_irwrite, a_pcwrite, a_regwrite, a_memwrite, a_branch, a_branch_ne,
                    a_instr_done, a_illegal_op};
    assign b_ctl = {b_iord, b_alusrca, b_regdst, b_memtoreg, b_alusrcb, b_pcsrc, b_aluop,
                    b_irwrite, b_pcwrite, b_regwrite, b_memwrite, b_branch, b_branch_ne,
                    b_instr_done, b_illegal_op};

    typedef struct {
        bit          sel;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [15:0] ret;
        string       name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sel = 1'b0;
    int   exp_ret = 0;
    int   ret_mask = 16'hFFFF;

    // Expected outputs for one cycle, taken from the state output table.
    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic [5:0] o,
                                            input logic mr, input logic rst,
                                            input bit bne, input bit ori);
        logic iord, asa, rd, m2r;
        logic [1:0] asb, pcs, aop;
        logic irw, pcw, rw, mw, br, bn, dn, il;
        iord = 0; asa = 0; rd = 0; m2r = 0; asb = 0; pcs = 0; aop = 0;
        irw = 0; pcw = 0; rw = 0; mw = 0; br = 0; bn = 0; dn = 0; il = 0;
        case (st)
            4'd0:  begin asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin
                asb = 2'b11;
                il  = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                        o == 6'b000100 || o == 6'b001000 || o == 6'b000010 ||
                        (bne && o == 6'b000101) || (ori && o == 6'b001101));
            end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin iord = 1; end
            4'd4:  begin m2r = 1; rw = 1; dn = 1; end
            4'd5:  begin iord = 1; mw = 1; dn = mr; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; dn = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; dn = 1; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: begin rw = 1; dn = 1; end
            4'd11: begin pcs = 2'b10; pcw = 1; dn = 1; end
            4'd12: if (ori) begin asa = 1; asb = 2'b10; aop = 2'b11; end
            4'd13: if (ori) begin rw = 1; dn = 1; end
            4'd14: if (bne) begin asa = 1; aop = 2'b01; pcs = 2'b01; bn = 1; dn = 1; end
            default: ;
        endcase
        if (rst) begin
            irw = 0; pcw = 0; rw = 0; mw = 0; br = 0; bn = 0; dn = 0; il = 0;
        end
        return {iord, asa, rd, m2r, asb, pcs, aop, irw, pcw, rw, mw, br, bn, dn, il};
    endfunction

    // One driven cycle with its hand-written expected state.
    task automatic cyc(input string nm, input logic [5:0] o, input logic mr,
                       input logic rst, input logic [3:0] st);
        exp_t e;
        logic [17:0] c;
        @(posedge clk);
        #1;
        op        = o;
        mem_ready = mr;
        reset     = rst;
        c = exp_ctl(st, o, mr, rst, !sel, !sel);
        e.sel  = sel;
        e.st   = st;
        e.ctl  = c;
        e.ret  = 16'(exp_ret);
        e.name = nm;
        q.push_back(e);
        if (rst) exp_ret = 0;
        else if (c[1]) exp_ret = (exp_ret + 1) & ret_mask;
    endtask

    // States as hex nibbles and mem_ready as bits, first cycle leftmost.
    task automatic seq(input string nm, input logic [5:0] o, input logic [31:0] sts,
                       input logic [7:0] mrs, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(nm, o, mrs[n-1-i], 1'b0, sts[4*(n-1-i) +: 4]);
        end
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            op = 6'd0;
            mem_ready = 1'b1;
        end
        exp_ret = 0;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]  g_st;
        logic [17:0] g_ctl;
        logic [15:0] g_ret;
        if (q.size() > 0) begin
            e = q.pop_front();
            g_st  = e.sel ? b_state : a_state;
            g_ctl = e.sel ? b_ctl : a_ctl;
            g_ret = e.sel ? {14'd0, b_retired} : a_retired;
            checks++;
            if (g_st !== e.st) begin
                errors++;
                $display("FAIL %s state: got %0d expected %0d", e.name, g_st, e.st);
            end
            checks++;
            if (g_ctl !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl (state %0d): got %05h expected %05h", e.name, e.st, g_ctl, e.ctl);
            end
            checks++;
            if (g_ret !== e.ret) begin
                errors++;
                $display("FAIL %s retired: got %0d expected %0d", e.name, g_ret, e.ret);
            end
        end
    end

    initial begin
        // ---- instance A: defaults ----
        sel = 1'b0;
        ret_mask = 16'hFFFF;
        hold_reset(2);
        seq("lw",        6'b100011, 32'h01234,   8'h1F, 5);
        seq("sw_wait",   6'b101011, 32'h0125555, 8'h71, 7);
        seq("fetch_wait",6'b000000, 32'h000167,  8'h0F, 6);
        seq("rtype",     6'b000000, 32'h0167,    8'h0F, 4);
        seq("addi",      6'b001000, 32'h019A,    8'h0F, 4);
        seq("ori",       6'b001101, 32'h01CD,    8'h0F, 4);
        seq("beq",       6'b000100, 32'h018,     8'h07, 3);
        seq("bne",       6'b000101, 32'h01E,     8'h07, 3);
        seq("j",         6'b000010, 32'h01B,     8'h07, 3);
        seq("illegal",   6'b111111, 32'h01,      8'h03, 2);
        seq("after_ill", 6'b000010, 32'h01B,     8'h07, 3);

        // ---- instance B: no ORI/BNE, 2-bit counter ----
        sel = 1'b1;
        ret_mask = 3;
        hold_reset(2);
        seq("bne_off",   6'b000101, 32'h01,      8'h03, 2);
        seq("ori_off",   6'b001101, 32'h01,      8'h03, 2);
        seq("ill_b",     6'b111111, 32'h01,      8'h03, 2);
        for (int k = 0; k < 5; k++) begin
            seq("j_wrap", 6'b000010, 32'h01B, 8'h07, 3);
        end
        seq("lw_abort",  6'b100011, 32'h012,     8'h07, 3);
        cyc("rst_memrd", 6'b100011, 1'b0, 1'b1, 4'd3);
        seq("post_rst",  6'b000010, 32'h01B,     8'h07, 3);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
